// File: rtl/shared_mem_arb.sv
// Single-port word memory shared by NPORTS valid/ready requestors, one access per cycle.
// Response RD_LAT cycles after acceptance; unaccepted requests stall in place (nothing latched).
module shared_mem_arb #(
  parameter int NPORTS    = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 1024,
  parameter int RD_LAT    = 1,
  parameter int PRIO_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NPORTS-1:0]          req_valid,
  output logic [NPORTS-1:0]          req_ready,
  input  logic [NPORTS-1:0]          req_we,
  input  logic [NPORTS*ADDR_W-1:0]   req_addr,
  input  logic [NPORTS*DATA_W-1:0]   req_wdata,
  input  logic [NPORTS*DATA_W/8-1:0] req_be,
  output logic [NPORTS-1:0]          rsp_valid,
  output logic [NPORTS*DATA_W-1:0]   rsp_rdata,
  output logic [NPORTS-1:0]          rsp_err
);
  localparam int  BYTES   = DATA_W / 8;
  localparam int  OFF_W   = $clog2(BYTES);
  localparam int  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int  PTR_W   = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam bit  CAN_OOR = (ADDR_W - OFF_W) > IDX_W;

  typedef struct packed {
    logic              vld;
    logic [PTR_W-1:0]  port;
    logic              err;
    logic [DATA_W-1:0] data;
  } rsp_ent_t;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  rsp_ent_t          pipe_q [RD_LAT];
  rsp_ent_t          pipe_d [RD_LAT];
  logic [DATA_W-1:0] mem [DEPTH];

  logic              gnt_found;
  logic [PTR_W-1:0]  gnt_idx;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] sel_word;
  logic [DATA_W-1:0] sel_wdata;
  logic [BYTES-1:0]  sel_be;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_oor;
  logic              do_wr;
  logic [DATA_W-1:0] rd_word;

  // rst_n is active-high here: 1 holds the block in reset.
  // First pass scans from the pointer upward, second pass wraps to the low ports.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (!gnt_found && req_valid[p] && ((PRIO_MODE == 1) || (p >= int'(ptr_q)))) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(p);
      end
    end
    for (int p = 0; p < NPORTS; p++) begin
      if (!gnt_found && req_valid[p]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(p);
      end
    end
    if (rst_n) gnt_found = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (gnt_idx == PTR_W'(p)) begin
        req_ready[p] = gnt_found;
        sel_we       = req_we[p];
        sel_addr     = req_addr[p*ADDR_W +: ADDR_W];
        sel_wdata    = req_wdata[p*DATA_W +: DATA_W];
        sel_be       = req_be[p*BYTES +: BYTES];
      end
    end
    sel_word = sel_addr >> OFF_W;
    sel_idx  = sel_word[IDX_W-1:0];
    sel_oor  = CAN_OOR && (sel_word >= ADDR_W'(DEPTH));
    do_wr    = gnt_found && sel_we && !sel_oor;
    rd_word  = mem[sel_idx];
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_found && (PRIO_MODE == 0))
      ptr_d = (int'(gnt_idx) == NPORTS - 1) ? '0 : gnt_idx + PTR_W'(1);
    pipe_d[0].vld  = gnt_found;
    pipe_d[0].port = gnt_idx;
    pipe_d[0].err  = gnt_found && sel_oor;
    pipe_d[0].data = (gnt_found && !sel_we && !sel_oor) ? rd_word : '0;
    for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      ptr_q <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      for (int b = 0; b < BYTES; b++)
        if (sel_be[b]) mem[sel_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_err   = '0;
    rsp_rdata = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (!rst_n && pipe_q[RD_LAT-1].vld && (pipe_q[RD_LAT-1].port == PTR_W'(p))) begin
        rsp_valid[p]                  = 1'b1;
        rsp_err[p]                    = pipe_q[RD_LAT-1].err;
        rsp_rdata[p*DATA_W +: DATA_W] = pipe_q[RD_LAT-1].data;
      end
    end
  end

endmodule

// File: tb/tb_shared_mem_arb.sv
// Scoreboard bench: dut_a is round-robin with RD_LAT=2, dut_b fixed priority with RD_LAT=3.
module tb_shared_mem_arb;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        sel = 1'b0;
  req_t        cur [2];
  logic [1:0]  vld = '0;
  logic [1:0]  acc_last = '0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  int          m_ptr = 0;
  int          gcnt [2];
  int          gtot = 0;

  req_t        q0 [$];
  req_t        q1 [$];
  exp_t        sbq [$];
  logic [31:0] mm [int unsigned];
  req_t        pcur [2];
  logic [1:0]  pvld = '0;
  logic [1:0]  pacc = '0;

  logic [1:0]  req_we;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_be;
  logic [1:0]  rdy_a, rdy_b, rv_a, rv_b, er_a, er_b;
  logic [63:0] rd_a, rd_b;

  assign req_we    = {cur[1].we, cur[0].we};
  assign req_addr  = {cur[1].addr, cur[0].addr};
  assign req_wdata = {cur[1].wdata, cur[0].wdata};
  assign req_be    = {cur[1].be, cur[0].be};

  shared_mem_arb #(.NPORTS(2), .DATA_W(32), .ADDR_W(32), .DEPTH(1024), .RD_LAT(2), .PRIO_MODE(0)) dut_a (
    .clk(clk), .rst_n(rst), .req_valid(vld), .req_ready(rdy_a), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv_a), .rsp_rdata(rd_a), .rsp_err(er_a));

  shared_mem_arb #(.NPORTS(2), .DATA_W(32), .ADDR_W(32), .DEPTH(1024), .RD_LAT(3), .PRIO_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst), .req_valid(vld), .req_ready(rdy_b), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv_b), .rsp_rdata(rd_b), .rsp_err(er_b));

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic req_t mk(input logic we, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] be);
    req_t r;
    r.we = we; r.addr = a; r.wdata = d; r.be = be;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: arbiter, memory image and response scoreboard.
  always @(negedge clk) begin : monitor
    logic [1:0]  rdy, rv, er, exp_rdy, exp_rv, exp_er;
    logic [63:0] rd, exp_rd;
    logic [31:0] w;
    int          g, lat;
    int unsigned widx;
    exp_t        e;
    rdy = sel ? rdy_b : rdy_a;
    rv  = sel ? rv_b  : rv_a;
    er  = sel ? er_b  : er_a;
    rd  = sel ? rd_b  : rd_a;
    lat = sel ? 3 : 2;
    g = -1;
    exp_rdy = '0;
    if (rst) begin
      m_ptr = 0;
      sbq.delete();
    end else if (sel) begin
      if (vld[0]) g = 0; else if (vld[1]) g = 1;
    end else begin
      if (vld[m_ptr]) g = m_ptr; else if (vld[1-m_ptr]) g = 1 - m_ptr;
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 96'(rdy), 96'(exp_rdy));

    exp_rv = '0; exp_er = '0; exp_rd = '0;
    if (!rst && sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      exp_rv[e.port] = 1'b1;
      exp_er[e.port] = e.err;
      exp_rd[e.port*32 +: 32] = e.data;
    end
    chk("rsp_valid", 96'(rv), 96'(exp_rv));
    chk("rsp_err", 96'(er), 96'(exp_er));
    chk("rsp_rdata", 96'(rd), 96'(exp_rd));

    if (g >= 0) begin
      widx   = cur[g].addr >> 2;
      e.port = g;
      e.due  = cyc + lat;
      e.err  = (widx >= 1024);
      e.data = '0;
      if (!e.err) begin
        if (cur[g].we) begin
          w = mm.exists(widx) ? mm[widx] : 32'h0;
          for (int b = 0; b < 4; b++)
            if (cur[g].be[b]) w[b*8 +: 8] = cur[g].wdata[b*8 +: 8];
          if (mm.exists(widx) || cur[g].be != 4'h0) mm[widx] = w;
        end else begin
          e.data = mm[widx];
        end
      end
      sbq.push_back(e);
      if (!sel) m_ptr = 1 - g;
      if (gtot < 8) gcnt[g]++;
      gtot++;
    end

    for (int p = 0; p < 2; p++)
      if (pvld[p] && !pacc[p])
        chk("req_hold", {26'h0, vld[p], cur[p]}, {26'h0, 1'b1, pcur[p]});
    pvld = vld;
    pcur = cur;
    acc_last = rdy & vld;
    pacc = acc_last;
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (vld[0] && acc_last[0]) vld[0] = 1'b0;
    if (!vld[0] && q0.size() > 0) begin cur[0] = q0.pop_front(); vld[0] = 1'b1; end
    if (vld[1] && acc_last[1]) vld[1] = 1'b0;
    if (!vld[1] && q1.size() > 0) begin cur[1] = q1.pop_front(); vld[1] = 1'b1; end
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || vld != 2'b00 || sbq.size() > 0) && n < 300) begin
      step();
      n++;
    end
    chk("drain_timeout", 96'(n >= 300), 96'(0));
  endtask

  task automatic fair_window();
    gtot = 0; gcnt[0] = 0; gcnt[1] = 0;
    for (int i = 0; i < 8; i++) begin
      q0.push_back(mk(1'b1, 32'h100 + 32'(4*i), 32'hA000 + 32'(i), 4'hF));
      q1.push_back(mk(1'b1, 32'h200 + 32'(4*i), 32'hB000 + 32'(i), 4'hF));
    end
    drain();
  endtask

  initial begin : stim
    int n;
    cur[0] = '0; cur[1] = '0;
    gcnt[0] = 0; gcnt[1] = 0;

    // Both ports valid throughout reset; nothing may be granted.
    q0.push_back(mk(1'b1, 32'h10, 32'hDEADBEEF, 4'hF));
    q0.push_back(mk(1'b0, 32'h10, 32'h0, 4'h0));
    q1.push_back(mk(1'b1, 32'h40, 32'h12345678, 4'hF));
    q1.push_back(mk(1'b0, 32'h40, 32'h0, 4'h0));
    repeat (3) step();
    rst = 1'b0;
    drain();

    // Byte enables plus write-then-read of the same word back to back.
    q0.push_back(mk(1'b1, 32'h20, 32'h11223344, 4'hF));
    q0.push_back(mk(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101));
    q0.push_back(mk(1'b0, 32'h20, 32'h0, 4'h0));
    q0.push_back(mk(1'b0, 32'h22, 32'h0, 4'h0));
    drain();

    // Out-of-range accesses and be=0 writes.
    q1.push_back(mk(1'b1, 32'h0, 32'hCAFEF00D, 4'hF));
    drain();
    q0.push_back(mk(1'b0, 32'h1000, 32'h0, 4'h0));
    q1.push_back(mk(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF));
    drain();
    q0.push_back(mk(1'b0, 32'h0, 32'h0, 4'h0));
    q1.push_back(mk(1'b1, 32'h0, 32'h0, 4'h0));
    drain();
    q0.push_back(mk(1'b0, 32'h0, 32'h0, 4'h0));
    q0.push_back(mk(1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0));
    drain();

    fair_window();
    chk("rr_grants_p0", 96'(gcnt[0]), 96'(4));
    chk("rr_grants_p1", 96'(gcnt[1]), 96'(4));

    // Switch to the fixed-priority, RD_LAT=3 instance.
    sel = 1'b1;
    rst = 1'b1;
    mm.delete();
    step(); step();
    rst = 1'b0;
    fair_window();
    chk("prio_grants_p0", 96'(gcnt[0]), 96'(8));
    chk("prio_grants_p1", 96'(gcnt[1]), 96'(0));

    q0.push_back(mk(1'b1, 32'h0, 32'h5A5A5A5A, 4'hF));
    q1.push_back(mk(1'b0, 32'h1000, 32'h0, 4'h0));
    q0.push_back(mk(1'b0, 32'h0, 32'h0, 4'h0));
    drain();

    // Read accepted, then a one-cycle reset: its response must never appear.
    q0.push_back(mk(1'b0, 32'h0, 32'h0, 4'h0));
    n = 0;
    do begin
      step();
      n++;
    end while (!acc_last[0] && n < 20);
    chk("midflight_accept", 96'(acc_last[0]), 96'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (8) step();
    chk("sb_empty", 96'(sbq.size()), 96'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
